// File: rtl/output_arb_buf_if.sv
// Handshake bundle between the four routing-direction requesters, the arbiter
// buffer and the outgoing link of one router output port.
interface output_arb_buf_if #(
    parameter int PW = 64
);
    logic          req_0;
    logic          req_1;
    logic          req_2;
    logic          req_3;
    logic [PW-1:0] packet_0;
    logic [PW-1:0] packet_1;
    logic [PW-1:0] packet_2;
    logic [PW-1:0] packet_3;
    logic          full_0;
    logic          full_1;
    logic          full_2;
    logic          full_3;
    logic          link_full;
    logic          link_valid;
    logic [PW-1:0] link_packet;
    logic          link_pop;

    modport master (
        input  req_0, req_1, req_2, req_3,
        input  packet_0, packet_1, packet_2, packet_3,
        input  link_full,
        output full_0, full_1, full_2, full_3,
        output link_valid, link_packet, link_pop
    );

    modport slave (
        output req_0, req_1, req_2, req_3,
        output packet_0, packet_1, packet_2, packet_3,
        output link_full,
        input  full_0, full_1, full_2, full_3,
        input  link_valid, link_packet, link_pop
    );
endinterface

// File: rtl/output_arb_buf.sv
// Output-port arbiter and buffer: a rotating time-slot token grants one of four
// requesters per cycle into a small FIFO whose head drives the outgoing link.
module output_arb_buf #(
    parameter int DEPTH = 4,
    parameter int PW    = 64
) (
    input  logic              clk,
    input  logic              reset,
    output_arb_buf_if.master  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [1:0]    r_tok;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_mem [DEPTH];

    logic [3:0]    w_req;
    logic [3:0]    w_full;
    logic [PW-1:0] w_pkt [4];
    logic [PW-1:0] w_push_data;
    logic          w_cnt_full;
    logic          w_push;
    logic          w_pop;
    logic          w_valid;

    always_comb begin
        w_req    = {bus.req_3, bus.req_2, bus.req_1, bus.req_0};
        w_pkt[0] = bus.packet_0;
        w_pkt[1] = bus.packet_1;
        w_pkt[2] = bus.packet_2;
        w_pkt[3] = bus.packet_3;
    end

    // Full flags come from registers only, so requesters may use them combinationally.
    assign w_cnt_full = (r_count == CNT_FULL);

    always_comb begin
        w_full = '1;
        for (int unsigned i = 0; i < 4; i++) begin
            w_full[i] = (r_tok != 2'(i)) || w_cnt_full;
        end
    end

    assign w_push      = w_req[r_tok] && !w_full[r_tok];
    assign w_push_data = w_pkt[r_tok];
    assign w_valid     = (r_count != '0);
    assign w_pop       = w_valid && !bus.link_full;

    assign bus.full_0      = w_full[0];
    assign bus.full_1      = w_full[1];
    assign bus.full_2      = w_full[2];
    assign bus.full_3      = w_full[3];
    assign bus.link_valid  = w_valid;
    assign bus.link_packet = w_valid ? r_mem[r_rd_ptr] : '0;
    assign bus.link_pop    = w_pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tok    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_tok <= r_tok + 2'd1;
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; link_packet is masked while the buffer is empty.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_push_data;
    end
endmodule

// File: tb/tb_output_arb_buf.sv
// Directed bench for output_arb_buf: per-cycle vector table plus a hand-written
// asynchronous-reset sequence.
module tb_output_arb_buf;
    localparam int PW = 64;

    typedef struct {
        logic [3:0]      req;
        logic [3:0][7:0] pk;
        logic            lf;
        logic [3:0]      efull;
        logic            evalid;
        logic [7:0]      epkt;
        logic            epop;
    } vec_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    vec_t tv[$];

    output_arb_buf_if #(.PW(PW)) bus ();

    output_arb_buf #(.DEPTH(4), .PW(PW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] req, input logic [31:0] pk, input logic lf,
                       input logic [3:0] efull, input logic evalid, input logic [7:0] epkt,
                       input logic epop);
        vec_t v;
        v.req = req; v.pk = pk; v.lf = lf;
        v.efull = efull; v.evalid = evalid; v.epkt = epkt; v.epop = epop;
        tv.push_back(v);
    endtask

    task automatic drive(input logic [3:0] req, input logic [3:0][7:0] pk, input logic lf);
        bus.req_0 = req[0]; bus.req_1 = req[1]; bus.req_2 = req[2]; bus.req_3 = req[3];
        bus.packet_0 = {56'h0, pk[0]};
        bus.packet_1 = {56'h0, pk[1]};
        bus.packet_2 = {56'h0, pk[2]};
        bus.packet_3 = {56'h0, pk[3]};
        bus.link_full = lf;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] efull, input logic evalid,
                           input logic [7:0] epkt, input logic epop);
        chk({tag, " full"}, 64'({bus.full_3, bus.full_2, bus.full_1, bus.full_0}), 64'(efull));
        chk({tag, " valid"}, 64'(bus.link_valid), 64'(evalid));
        chk({tag, " packet"}, bus.link_packet, {56'h0, epkt});
        chk({tag, " pop"}, 64'(bus.link_pop), 64'(epop));
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // idle token rotation
        add(4'b0000, 32'h0, 1'b0, 4'b1110, 1'b0, 8'h00, 1'b0);
        add(4'b0000, 32'h0, 1'b0, 4'b1101, 1'b0, 8'h00, 1'b0);
        add(4'b0000, 32'h0, 1'b0, 4'b1011, 1'b0, 8'h00, 1'b0);
        add(4'b0000, 32'h0, 1'b0, 4'b0111, 1'b0, 8'h00, 1'b0);
        add(4'b0000, 32'h0, 1'b0, 4'b1110, 1'b0, 8'h00, 1'b0);
        add(4'b0000, 32'h0, 1'b0, 4'b1101, 1'b0, 8'h00, 1'b0);
        add(4'b0000, 32'h0, 1'b0, 4'b1011, 1'b0, 8'h00, 1'b0);
        add(4'b0000, 32'h0, 1'b0, 4'b0111, 1'b0, 8'h00, 1'b0);
        // single requester 2 holding A5 from tok=0
        add(4'b0100, 32'h00A50000, 1'b0, 4'b1110, 1'b0, 8'h00, 1'b0);
        add(4'b0100, 32'h00A50000, 1'b0, 4'b1101, 1'b0, 8'h00, 1'b0);
        add(4'b0100, 32'h00A50000, 1'b0, 4'b1011, 1'b0, 8'h00, 1'b0);
        add(4'b0000, 32'h0,        1'b0, 4'b0111, 1'b1, 8'hA5, 1'b1);
        add(4'b0000, 32'h0,        1'b0, 4'b1110, 1'b0, 8'h00, 1'b0);
        add(4'b0000, 32'h0,        1'b0, 4'b1101, 1'b0, 8'h00, 1'b0);
        add(4'b0000, 32'h0,        1'b0, 4'b1011, 1'b0, 8'h00, 1'b0);
        add(4'b0000, 32'h0,        1'b0, 4'b0111, 1'b0, 8'h00, 1'b0);
        // all four requesting, link open
        add(4'b1111, 32'h04030201, 1'b0, 4'b1110, 1'b0, 8'h00, 1'b0);
        add(4'b1111, 32'h04030201, 1'b0, 4'b1101, 1'b1, 8'h01, 1'b1);
        add(4'b1111, 32'h04030201, 1'b0, 4'b1011, 1'b1, 8'h02, 1'b1);
        add(4'b1111, 32'h04030201, 1'b0, 4'b0111, 1'b1, 8'h03, 1'b1);
        add(4'b0000, 32'h0,        1'b0, 4'b1110, 1'b1, 8'h04, 1'b1);
        add(4'b0000, 32'h0,        1'b0, 4'b1101, 1'b0, 8'h00, 1'b0);
        // fill with link blocked, then drain
        add(4'b1111, 32'h44332211, 1'b1, 4'b1011, 1'b0, 8'h00, 1'b0);
        add(4'b1111, 32'h44332211, 1'b1, 4'b0111, 1'b1, 8'h33, 1'b0);
        add(4'b1111, 32'h44332211, 1'b1, 4'b1110, 1'b1, 8'h33, 1'b0);
        add(4'b1111, 32'h44332211, 1'b1, 4'b1101, 1'b1, 8'h33, 1'b0);
        add(4'b1111, 32'h44332211, 1'b1, 4'b1111, 1'b1, 8'h33, 1'b0);
        add(4'b1111, 32'h44332211, 1'b1, 4'b1111, 1'b1, 8'h33, 1'b0);
        add(4'b1111, 32'h44332211, 1'b0, 4'b1111, 1'b1, 8'h33, 1'b1);
        add(4'b0000, 32'h0,        1'b0, 4'b1101, 1'b1, 8'h44, 1'b1);
        add(4'b0000, 32'h0,        1'b0, 4'b1011, 1'b1, 8'h11, 1'b1);
        add(4'b0000, 32'h0,        1'b0, 4'b0111, 1'b1, 8'h22, 1'b1);
        add(4'b0000, 32'h0,        1'b0, 4'b1110, 1'b0, 8'h00, 1'b0);
        // count=3 with simultaneous push/pop across the pointer wrap
        add(4'b1111, 32'h54535251, 1'b1, 4'b1101, 1'b0, 8'h00, 1'b0);
        add(4'b1111, 32'h54535251, 1'b1, 4'b1011, 1'b1, 8'h52, 1'b0);
        add(4'b1111, 32'h54535251, 1'b1, 4'b0111, 1'b1, 8'h52, 1'b0);
        add(4'b1111, 32'h54535251, 1'b0, 4'b1110, 1'b1, 8'h52, 1'b1);
        add(4'b1111, 32'h64636261, 1'b0, 4'b1101, 1'b1, 8'h53, 1'b1);
        add(4'b0000, 32'h0,        1'b0, 4'b1011, 1'b1, 8'h54, 1'b1);
        add(4'b0000, 32'h0,        1'b0, 4'b0111, 1'b1, 8'h51, 1'b1);
        add(4'b0000, 32'h0,        1'b0, 4'b1110, 1'b1, 8'h62, 1'b1);
        add(4'b0000, 32'h0,        1'b0, 4'b1101, 1'b0, 8'h00, 1'b0);

        drive(4'b0000, 32'h0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_out("reset", 4'b1110, 1'b0, 8'h00, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;

        foreach (tv[k]) begin
            drive(tv[k].req, tv[k].pk, tv[k].lf);
            @(negedge clk);
            chk_out($sformatf("vec%0d", k), tv[k].efull, tv[k].evalid, tv[k].epkt, tv[k].epop);
            @(posedge clk);
            #1;
        end

        // Buffer three packets (tok 2,3,0), then assert reset between edges.
        drive(4'b1111, 32'h84838281, 1'b1);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1 drive(4'b0000, 32'h0, 1'b1);
        #1 chk_out("prereset", 4'b1101, 1'b1, 8'h83, 1'b0);
        bus.link_full = 1'b0;
        #1 chk("prereset pop", 64'(bus.link_pop), 64'd1);
        reset = 1'b1;
        #1 chk_out("async_reset", 4'b1110, 1'b0, 8'h00, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        drive(4'b0001, 32'h00000077, 1'b1);
        @(negedge clk);
        chk_out("post_reset0", 4'b1110, 1'b0, 8'h00, 1'b0);
        @(posedge clk);
        #1 drive(4'b0000, 32'h0, 1'b1);
        @(negedge clk);
        chk_out("post_reset1", 4'b1101, 1'b1, 8'h77, 1'b0);
        bus.link_full = 1'b0;
        #1 chk("post_reset1 pop", 64'(bus.link_pop), 64'd1);
        @(posedge clk);
        @(negedge clk);
        chk_out("post_reset2", 4'b1011, 1'b0, 8'h00, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk_out("post_reset3", 4'b0111, 1'b0, 8'h00, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
